// File: rtl/vend_pkg.sv
// Shared vending types: coin-amount width used by the vending FSM's cng/rtn outputs
// and the change dispenser's state encoding.
package vend_pkg;

    localparam int CNT_W = 3;

    typedef logic [CNT_W-1:0] amt_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EJECT,
        WAIT,
        GAP,
        DONE,
        FAULT
    } disp_state_t;

endpackage

// File: rtl/dispense_fifo.sv
// Pending change/refund requests. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits match.
module dispense_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/change_dispenser.sv
// Drives the coin hopper one coin at a time from buffered change/refund requests,
// confirming each eject via the coin sensor, retrying on timeout, latching a fault.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int GAP_CYC     = 8,
    parameter int RETRY_MAX   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pay_valid,
    input  amt_t        pay_amt,
    output logic        pay_ready,
    output logic        hop_eject,
    input  logic        hop_coin,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output amt_t        fault_owed,
    input  logic        fault_clr,
    output disp_state_t o_dbg_state
);

    // Handshake: a request transfers on the rising edge where pay_valid & pay_ready;
    // pay_ready is !full from registered FIFO state; zero amounts transfer but are not stored.

    // The timer is shared by the WAIT timeout and the GAP settle count.
    localparam int TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam int RTY_W   = $clog2(RETRY_MAX + 2);

    disp_state_t      r_state;
    amt_t             r_remaining;
    logic [RTY_W-1:0] r_retry;
    logic [TMR_W-1:0] r_timer;
    logic             r_hop_eject;
    logic             r_done;
    logic             r_fault;
    amt_t             r_fault_owed;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    amt_t             w_head;

    assign pay_ready   = ~w_full;
    assign w_push      = pay_valid & ~w_full & (pay_amt != '0);
    assign w_pop       = (r_state == IDLE) & ~w_empty & ~r_fault;

    assign hop_eject   = r_hop_eject;
    assign done        = r_done;
    assign fault       = r_fault;
    assign fault_owed  = r_fault_owed;
    assign busy        = (r_state != IDLE) | ~w_empty;
    assign o_dbg_state = r_state;

    dispense_fifo #(
        .W     (CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (pay_amt),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_remaining  <= '0;
            r_retry      <= '0;
            r_timer      <= '0;
            r_hop_eject  <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_owed <= '0;
        end else begin
            r_hop_eject <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state     <= LOAD;
                        r_remaining <= w_head;
                        r_retry     <= '0;
                    end
                end
                LOAD: begin
                    r_state     <= EJECT;
                    r_hop_eject <= 1'b1;
                end
                EJECT: begin
                    r_state <= WAIT;
                    r_timer <= '0;
                end
                WAIT: begin
                    // A sense on the timeout cycle itself still counts as delivered.
                    if (hop_coin) begin
                        if (r_remaining != '0) r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= GAP;
                            r_timer <= '0;
                            r_retry <= '0;
                        end
                    end else if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        if (r_retry < RTY_W'(RETRY_MAX)) begin
                            r_retry     <= r_retry + RTY_W'(1);
                            r_state     <= EJECT;
                            r_hop_eject <= 1'b1;
                        end else begin
                            r_state      <= FAULT;
                            r_fault      <= 1'b1;
                            r_fault_owed <= r_remaining;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                GAP: begin
                    if (r_timer == TMR_W'(GAP_CYC - 1)) begin
                        r_state     <= EJECT;
                        r_hop_eject <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                FAULT: begin
                    // Clearing abandons the coins still owed on this request.
                    if (fault_clr) begin
                        r_state      <= IDLE;
                        r_fault      <= 1'b0;
                        r_fault_owed <= '0;
                        r_remaining  <= '0;
                        r_retry      <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed and randomized requests against a hopper
// responder, with eject/done timing predicted from the dispensing rules.
module tb_change_dispenser;
    import vend_pkg::*;

    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 1000;
    localparam int GAP_CYC     = 8;
    localparam int RETRY_MAX   = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pay_valid = 1'b0;
    amt_t        pay_amt = '0;
    logic        hop_coin = 1'b0;
    logic        fault_clr = 1'b0;
    logic        pay_ready;
    logic        hop_eject;
    logic        busy;
    logic        done;
    logic        fault;
    amt_t        fault_owed;
    disp_state_t dbg_state;

    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    change_dispenser #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GAP_CYC     (GAP_CYC),
        .RETRY_MAX   (RETRY_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pay_valid   (pay_valid),
        .pay_amt     (pay_amt),
        .pay_ready   (pay_ready),
        .hop_eject   (hop_eject),
        .hop_coin    (hop_coin),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_owed  (fault_owed),
        .fault_clr   (fault_clr),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    int plan_q[$];     // per eject: -1 = hopper stays silent, d>0 = coin sensed d cycles later
    int resp_q[$];
    int plan_idx;
    int ej_q[$];       // observed eject cycles
    int done_q[$];     // observed done cycles
    int exp_ej[$];     // predicted eject cycles
    int exp_done[$];   // predicted done cycles
    int exp_end;
    bit exp_flt;
    int exp_owed;
    int coin_cd = 0;
    int stray_at = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- hopper responder / monitor ----------------
    initial forever begin
        @(negedge clk);
        hop_coin = 1'b0;
        if (coin_cd > 0) begin
            coin_cd--;
            if (coin_cd == 0) hop_coin = 1'b1;
        end
        if (cyc == stray_at) hop_coin = 1'b1;
        if (hop_eject === 1'b1) begin
            int r;
            ej_q.push_back(cyc);
            r = (resp_q.size() > 0) ? resp_q.pop_front() : -1;
            if (r > 0) coin_cd = r;
        end
        if (done === 1'b1) done_q.push_back(cyc);
    end

    // ---------------- reference model ----------------
    // One request of amt coins, accepted (or released from IDLE) in cycle a.
    // First eject 3 cycles later; a sensed coin leads to a settle gap then the next
    // eject; a silent hopper costs a full timeout before the re-eject; more than
    // RETRY_MAX misses on one coin ends in a fault.
    task automatic predict(input int a, input int amt);
        int t, coins, misses, r;
        t = a + 3; coins = 0; misses = 0;
        exp_flt = 1'b0; exp_owed = 0;
        while (1) begin
            exp_ej.push_back(t);
            r = (plan_idx < plan_q.size()) ? plan_q[plan_idx] : -1;
            plan_idx++;
            if (r > 0) begin
                coins++;
                misses = 0;
                if (coins == amt) begin
                    exp_end = t + r + 1;
                    exp_done.push_back(exp_end);
                    break;
                end
                t = t + r + GAP_CYC + 1;
            end else if (misses == RETRY_MAX) begin
                exp_flt  = 1'b1;
                exp_owed = amt - coins;
                exp_end  = t + TIMEOUT_CYC + 1;
                break;
            end else begin
                misses++;
                t = t + TIMEOUT_CYC + 1;
            end
        end
    endtask

    task automatic clear_sb();
        ej_q.delete(); done_q.delete(); exp_ej.delete(); exp_done.delete();
        plan_idx = 0;
        resp_q = plan_q;
    endtask

    task automatic verify(input string tag);
        check($sformatf("%s eject_count", tag), ej_q.size(), exp_ej.size());
        for (int i = 0; i < exp_ej.size() && i < ej_q.size(); i++)
            check($sformatf("%s eject%0d_cycle", tag, i), ej_q[i], exp_ej[i]);
        check($sformatf("%s done_count", tag), done_q.size(), exp_done.size());
        for (int i = 0; i < exp_done.size() && i < done_q.size(); i++)
            check($sformatf("%s done%0d_cycle", tag, i), done_q[i], exp_done[i]);
        check($sformatf("%s fault", tag), fault, exp_flt);
        check($sformatf("%s fault_owed", tag), fault_owed, exp_flt ? exp_owed : 0);
        check($sformatf("%s busy", tag), busy, exp_flt);
    endtask

    // ---------------- driver ----------------
    task automatic run_req(input string tag, input int amt, input int stray_off);
        int a;
        clear_sb();
        @(negedge clk);
        a = cyc;
        check({tag, " pay_ready"}, pay_ready, 1);
        pay_valid = 1'b1;
        pay_amt   = CNT_W'(amt);
        if (stray_off > 0) stray_at = a + stray_off;
        predict(a, amt);
        @(negedge clk);
        pay_valid = 1'b0;
        while (cyc < exp_end + 2) @(negedge clk);
        #1;
        verify(tag);
        stray_at = -1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int a, c, amt;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst pay_ready", pay_ready, 1);
        check("rst hop_eject", hop_eject, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst fault", fault, 0);
        check("rst fault_owed", fault_owed, 0);
        check("rst state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b1;

        // single request, coin 5 cycles after each eject
        plan_q = '{5, 5, 5};
        run_req("single", 3, 0);

        // zero-amount request: accepted, no activity
        clear_sb();
        @(negedge clk);
        check("zero pay_ready", pay_ready, 1);
        pay_valid = 1'b1; pay_amt = '0;
        @(negedge clk);
        pay_valid = 1'b0;
        #1;
        check("zero busy_next", busy, 0);
        repeat (20) @(negedge clk);
        #1;
        check("zero ejects", ej_q.size(), 0);
        check("zero dones", done_q.size(), 0);

        // randomized requests with occasional single dropped coin
        for (int k = 0; k < 5; k++) begin
            amt = $urandom_range(1, 7);
            plan_q.delete();
            for (int j = 0; j < amt; j++) begin
                if ($urandom_range(0, 9) == 0) plan_q.push_back(-1);
                plan_q.push_back($urandom_range(1, 40));
            end
            run_req($sformatf("rand%0d", k), amt, 0);
        end

        // retry: first eject unanswered
        plan_q = '{-1, 4};
        run_req("retry", 1, 0);

        // sense on the exact timeout cycle counts; stray coin in GAP ignored
        plan_q = '{TIMEOUT_CYC, 3};
        run_req("edge_timeout", 2, 0);
        plan_q = '{5, 5};
        run_req("stray_gap", 2, 3 + 5 + 4);

        // stray coin while idle
        clear_sb();
        stray_at = cyc + 2;
        repeat (10) @(negedge clk);
        #1;
        stray_at = -1;
        check("stray_idle ejects", ej_q.size(), 0);
        check("stray_idle dones", done_q.size(), 0);
        check("stray_idle busy", busy, 0);

        // fault: one coin sensed, then a silent hopper
        plan_q = '{5};
        run_req("fault", 3, 0);
        check("fault state", dbg_state, FAULT);

        // backpressure while faulted: FIFO fills, no ejects
        clear_sb();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp pay_ready%0d", i), pay_ready, (i < FIFO_DEPTH) ? 1 : 0);
            pay_valid = 1'b1; pay_amt = CNT_W'(2);
        end
        @(negedge clk);
        pay_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("bp ejects", ej_q.size(), 0);
        check("bp fault_held", fault, 1);

        // clear fault: the four queued requests dispense back to back
        plan_q = '{5, 5, 5, 5, 5, 5, 5, 5};
        clear_sb();
        @(negedge clk);
        c = cyc;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        #1;
        check("clr fault", fault, 0);
        check("clr fault_owed", fault_owed, 0);
        a = c;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            predict(a, 2);
            a = exp_end;
        end
        while (cyc < exp_end + 2) @(negedge clk);
        #1;
        verify("after_clr");

        // reset in the middle of an eject with two requests queued
        plan_q.delete();
        clear_sb();
        @(negedge clk);
        a = cyc;
        for (int i = 0; i < 3; i++) begin
            pay_valid = 1'b1; pay_amt = CNT_W'(2);
            @(negedge clk);
        end
        pay_valid = 1'b0;
        #1;
        check("mid_rst eject_before", hop_eject, (cyc == a + 3) ? 1 : 0);
        rst = 1'b0;
        #1;
        check("mid_rst hop_eject", hop_eject, 0);
        check("mid_rst busy", busy, 0);
        check("mid_rst pay_ready", pay_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        check("mid_rst ejects", ej_q.size(), 1);
        check("mid_rst dones", done_q.size(), 0);
        check("mid_rst busy_after", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
